adder_share_arbiter: RTL and testbench
======================================

ADDER_SHARE_ARBITER -- requirements
Module: adder_share_arbiter

Interface
REQ-001 Parameter: NREQ, 4, number of requesters sharing the adder (2..8).
REQ-002 Parameter: WIDTH, 16, operand and result width in bits.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  NREQ  per-requester request strobe; bit i belongs to requester i.
REQ-006 Port: req_a  input  NREQ*WIDTH  operand A; requester i at bits [i*WIDTH +: WIDTH].
REQ-007 Port: req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
REQ-008 Port: req_sub  input  NREQ  1 = subtract (A-B), 0 = add.
REQ-009 Port: req_cin  input  NREQ  carry-in for add; ignored when req_sub=1.
REQ-010 Port: req_ack  output  NREQ  one-hot, one-cycle pulse: request i accepted this cycle.
REQ-011 Port: rsp_valid  output  1  result registers hold an unconsumed result.
REQ-012 Port: rsp_ready  input  1  consumer takes result when rsp_valid=1.
REQ-013 Port: rsp_id  output  clog2(NREQ)  index of requester that produced the result.
REQ-014 Port: rsp_sum  output  WIDTH  result.
REQ-015 Port: rsp_cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
REQ-016 Port: rsp_ovf  output  1  signed two's-complement overflow.

Function
REQ-017 Single shared adder datapath; at most one operation accepted per cycle; at most one result outstanding.
REQ-018 FSM states: IDLE (no result held), RESP (result held, rsp_valid=1).
REQ-019 Accept condition: any req_valid bit set AND (state IDLE, or state RESP with rsp_ready=1).
REQ-020 On accept: grant requester chosen by round-robin, pulse its req_ack bit, register result/id/flags, state -> RESP.
REQ-021 RESP with rsp_ready=1 and no accept: state -> IDLE, rsp_valid deasserts next cycle.
REQ-022 RESP with rsp_ready=0: all rsp_* outputs hold stable; req_ack all zero; no acceptance.
REQ-023 Latency: accept in cycle N -> rsp_valid=1 with that result from cycle N+1; back-to-back throughput one result per cycle while rsp_ready=1.
REQ-024 Round-robin: pointer P; grant lowest index i >= P (mod NREQ, wrapping) with req_valid[i]=1; after accept P = grant+1 mod NREQ.
REQ-025 Requester must hold req_valid and operands stable until its req_ack; arbiter samples operands only in the accept cycle.
REQ-026 Add: {cout,sum} = A + B + cin, (WIDTH+1)-bit arithmetic, sum truncated to WIDTH.
REQ-027 Subtract: {cout,sum} = A + ~B + 1.
REQ-028 ovf = (A[MSB] == B'[MSB]) AND (sum[MSB] != A[MSB]), B' = B for add, ~B for subtract.
REQ-029 req_ack is combinational from req_valid, state, rsp_ready and P; never more than one bit set.
REQ-030 req_valid bit dropping without ack is legal; that requester simply not granted.

Reset
REQ-031 Reset asserted: immediately state=IDLE, P=0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0, req_ack=0.
REQ-032 Reset mid-RESP discards held result; no response is produced for that request after release.
REQ-033 First accept after reset release follows REQ-024 with P=0.

Verification
REQ-034 Req0: a=65535, b=1, cin=0, sub=0 -> ack[0] pulse, next cycle rsp_valid=1, id=0, sum=0, cout=1, ovf=0.
REQ-035 Req1: a=5, b=7, sub=1 -> sum=65534, cout=0, ovf=0; a=32767, b=1, add -> sum=32768, ovf=1.
REQ-036 All four req_valid held, rsp_ready=1 from reset -> acks in order 0,1,2,3,0, one per cycle, rsp_id following one cycle later.
REQ-037 rsp_valid=1, rsp_ready=0 for 5 cycles with req2 pending -> rsp outputs frozen, no ack; rsp_ready=1 -> ack[2] same cycle, new result next cycle.
REQ-038 Reset pulsed while rsp_valid=1 -> rsp_valid=0 and all rsp outputs 0 within the reset cycle, no stale response after release, first grant to lowest valid index.

Source files
------------

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
//   Round-robin arbiter that shares one add/subtract datapath between NREQ
//   requesters. At most one operation is accepted per cycle and at most one
//   result is held in the response registers.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-high reset
//   req_valid  : per-requester request strobe (bit i = requester i)
//   req_a      : operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b      : operand B, same packing as req_a
//   req_sub    : 1 = A-B, 0 = A+B+cin
//   req_cin    : carry-in for add (ignored for subtract)
//   req_ack    : one-hot, combinational accept pulse
//   rsp_valid  : result registers hold an unconsumed result
//   rsp_ready  : consumer takes the result while rsp_valid=1
//   rsp_id     : index of the requester that produced the result
//   rsp_sum    : result
//   rsp_cout   : carry out of MSB (subtract: 1 = no borrow)
//   rsp_ovf    : signed two's-complement overflow
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ-1:0]          req_sub,
    input  logic [NREQ-1:0]          req_cin,
    output logic [NREQ-1:0]          req_ack,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf
);

    localparam int IDW = $clog2(NREQ);

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t             state;
    logic [IDW-1:0]     ptr;

    logic [NREQ-1:0]    rot;
    logic               found;
    logic [IDW-1:0]     off;
    logic [IDW:0]       gsum;
    logic [IDW-1:0]     grant;
    logic [IDW:0]       nsum;
    logic [IDW-1:0]     ptr_next;
    logic               accept;

    logic [WIDTH-1:0]   a_sel;
    logic [WIDTH-1:0]   b_sel;
    logic [WIDTH-1:0]   b_eff;
    logic               sub_sel;
    logic               cin_eff;
    logic [WIDTH:0]     full;
    logic               ovf;

    // Rotate the request vector so bit 0 corresponds to the pointer; the
    // first set bit then gives the offset of the round-robin winner.
    always_comb begin
        rot   = NREQ'({req_valid, req_valid} >> ptr);
        found = 1'b0;
        off   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = IDW'(k);
            end
        end
    end

    // Map offset back to an absolute index (mod NREQ, NREQ need not be 2^n).
    always_comb begin
        gsum = {1'b0, ptr} + {1'b0, off};
        if (gsum >= (IDW+1)'(NREQ)) begin
            grant = IDW'(gsum - (IDW+1)'(NREQ));
        end else begin
            grant = gsum[IDW-1:0];
        end
        nsum = {1'b0, grant} + (IDW+1)'(1);
        if (nsum >= (IDW+1)'(NREQ)) begin
            ptr_next = '0;
        end else begin
            ptr_next = nsum[IDW-1:0];
        end
    end

    // Gated by reset so no ack can escape while reset is held.
    always_comb begin
        accept  = !reset && found && (state == IDLE || rsp_ready);
        req_ack = '0;
        if (accept) begin
            req_ack[grant] = 1'b1;
        end
    end

    // Shared datapath: subtract is A + ~B + 1.
    always_comb begin
        a_sel   = req_a[grant*WIDTH +: WIDTH];
        b_sel   = req_b[grant*WIDTH +: WIDTH];
        sub_sel = req_sub[grant];
        b_eff   = sub_sel ? ~b_sel : b_sel;
        cin_eff = sub_sel ? 1'b1 : req_cin[grant];
        full    = {1'b0, a_sel} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
        ovf     = (a_sel[WIDTH-1] == b_eff[WIDTH-1]) &&
                  (full[WIDTH-1] != a_sel[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_ovf   <= 1'b0;
        end else if (accept) begin
            state     <= RESP;
            ptr       <= ptr_next;
            rsp_valid <= 1'b1;
            rsp_id    <= grant;
            rsp_sum   <= full[WIDTH-1:0];
            rsp_cout  <= full[WIDTH];
            rsp_ovf   <= ovf;
        end else if (state == RESP && rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Testbench for adder_share_arbiter (NREQ=4, WIDTH=16).
module tb_adder_share_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_sub;
    logic [3:0]  req_cin;
    logic [3:0]  req_ack;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_id;
    logic [15:0] rsp_sum;
    logic        rsp_cout;
    logic        rsp_ovf;

    adder_share_arbiter #(
        .NREQ  (4),
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_cin   (req_cin),
        .req_ack   (req_ack),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          id;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } rsp_t;

    rsp_t q[$];
    logic m_valid;
    int   m_ptr;
    int   nassert;
    int   nfail;
    int   order[5] = '{0, 1, 2, 3, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model(input int id, input logic [15:0] a, input logic [15:0] b,
                                   input logic sub, input logic cin);
        rsp_t r;
        int ua, ub, sa, sb, t, s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            t      = ua - ub;
            r.cout = (ua >= ub);
            s      = sa - sb;
        end else begin
            t      = ua + ub + int'(cin);
            r.cout = (t >= 65536);
            s      = sa + sb + int'(cin);
        end
        r.id  = id;
        r.sum = t[15:0];
        r.ovf = (s > 32767) || (s < -32768);
        return r;
    endfunction

    function automatic int rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (p + k) % 4;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                           input logic sub, input logic cin);
        req_valid[i]       = 1'b1;
        req_a[i*16 +: 16]  = a;
        req_b[i*16 +: 16]  = b;
        req_sub[i]         = sub;
        req_cin[i]         = cin;
    endtask

    // One clock cycle: check combinational ack and held response against the
    // model, update the scoreboard, then advance to the next falling edge.
    task automatic tick();
        int         g;
        logic       acc;
        logic [3:0] exp_ack;
        #1;
        acc     = (req_valid != 4'b0) && (!m_valid || rsp_ready);
        exp_ack = 4'b0;
        g       = -1;
        if (acc) begin
            g = rr_pick(req_valid, m_ptr);
            exp_ack[g] = 1'b1;
        end
        check("ack", 32'(req_ack), 32'(exp_ack));
        check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        if (m_valid && q.size() > 0) begin
            check("rsp_id",   32'(rsp_id),   32'(q[0].id));
            check("rsp_sum",  32'(rsp_sum),  32'(q[0].sum));
            check("rsp_cout", 32'(rsp_cout), 32'(q[0].cout));
            check("rsp_ovf",  32'(rsp_ovf),  32'(q[0].ovf));
        end
        if (m_valid && rsp_ready && q.size() > 0) void'(q.pop_front());
        if (acc) begin
            q.push_back(model(g, req_a[g*16 +: 16], req_b[g*16 +: 16], req_sub[g], req_cin[g]));
            m_ptr = (g + 1) % 4;
        end
        m_valid = acc || (m_valid && !rsp_ready);
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reset asserted mid-cycle: outputs must clear before the next clock edge.
    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id",    32'(rsp_id),    32'd0);
        check("rst_sum",   32'(rsp_sum),   32'd0);
        check("rst_cout",  32'(rsp_cout),  32'd0);
        check("rst_ovf",   32'(rsp_ovf),   32'd0);
        check("rst_ack",   32'(req_ack),   32'd0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
    endtask

    initial begin
        nassert   = 0;
        nfail     = 0;
        m_valid   = 1'b0;
        m_ptr     = 0;
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        req_cin   = '0;
        rsp_ready = 1'b1;

        @(negedge clk);
        do_reset();

        // Add wrapping to zero with carry out.
        set_req(0, 16'hffff, 16'h0001, 1'b0, 1'b0);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Subtract with borrow, then signed overflow on add.
        set_req(1, 16'd5, 16'd7, 1'b1, 1'b0);
        tick();
        req_valid = '0;
        tick();
        set_req(1, 16'h7fff, 16'h0001, 1'b0, 1'b0);
        tick();
        req_valid = '0;
        tick();
        // Subtract ignores cin; negative overflow.
        set_req(3, 16'h8000, 16'h0001, 1'b1, 1'b1);
        tick();
        req_valid = '0;
        tick();
        // Add with carry-in.
        set_req(2, 16'h1234, 16'h0ff0, 1'b0, 1'b1);
        tick();
        req_valid = '0;
        tick();
        tick();

        // All four requesting back-to-back from reset.
        do_reset();
        set_req(0, 16'h0010, 16'h0001, 1'b0, 1'b0);
        set_req(1, 16'h0020, 16'h0002, 1'b1, 1'b0);
        set_req(2, 16'hfff0, 16'h0020, 1'b0, 1'b1);
        set_req(3, 16'h4000, 16'hc000, 1'b1, 1'b0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check("rr_order", 32'(req_ack), 32'(1) << order[k]);
            tick();
        end
        req_valid = '0;
        tick();
        tick();

        // Consumer stall with requester 2 pending.
        set_req(0, 16'h00ff, 16'h0f00, 1'b0, 1'b0);
        tick();
        req_valid = '0;
        rsp_ready = 1'b0;
        set_req(2, 16'h4000, 16'h4000, 1'b0, 1'b0);
        repeat (5) tick();
        rsp_ready = 1'b1;
        #1;
        check("stall_release_ack", 32'(req_ack), 32'h4);
        tick();
        req_valid = '0;
        tick();
        tick();

        // Reset while a result is held.
        rsp_ready = 1'b0;
        set_req(3, 16'h0001, 16'h0002, 1'b1, 1'b0);
        tick();
        req_valid = '0;
        set_req(1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        set_req(3, 16'h3333, 16'h4444, 1'b0, 1'b0);
        tick();
        do_reset();
        rsp_ready = 1'b1;
        #1;
        check("post_rst_grant", 32'(req_ack), 32'h2);
        check("post_rst_valid", 32'(rsp_valid), 32'd0);
        tick();
        req_valid[1] = 1'b0;
        tick();
        req_valid = '0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule
